// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : Program-counter and instruction-fetch controller. Issues one
//            memory request at a time, registers the returned instruction,
//            and applies execute-stage corrections and optional branch
//            prediction to the next fetch address.
// Options  : `define PC_FETCH_CTRL_PREDICTION_EN to honour the predictor
//            inputs; otherwise they are ignored and fetch_pred_out is 0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            fetch_stall_in,
  input  logic            fetch_correction_en_in,
  input  logic [XLEN-1:0] fetch_correction_addr_in,
  input  logic            fetch_prediction_en_in,
  input  logic [XLEN-1:0] fetch_prediction_addr_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [31:0]     imem_data_in,
  output logic            fetch_valid_out,
  output logic [31:0]     fetch_instr_out,
  output logic [XLEN-1:0] fetch_pc_out,
  output logic            fetch_pred_out
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t          state_q,  state_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] shadow_q, shadow_d;
  logic            valid_q,  valid_d;
  logic [31:0]     instr_q,  instr_d;
  logic [XLEN-1:0] fpc_q,    fpc_d;
  logic            pred_q,   pred_d;

  logic            w_pred_en;
  logic [XLEN-1:0] w_pred_addr;

`ifdef PC_FETCH_CTRL_PREDICTION_EN
  assign w_pred_en   = fetch_prediction_en_in;
  assign w_pred_addr = fetch_prediction_addr_in;
`else
  // Predictor inputs are intentionally left unconnected in this build.
  logic w_unused_pred;
  assign w_unused_pred = fetch_prediction_en_in ^ (^fetch_prediction_addr_in);
  assign w_pred_en     = 1'b0;
  assign w_pred_addr   = '0;
`endif

  // Memory request is live in REQ and while draining an abandoned request.
  assign imem_req_out    = (state_q == ST_REQ) || (state_q == ST_FLUSH);
  assign imem_addr_out   = (state_q == ST_FLUSH) ? shadow_q : pc_q;
  assign fetch_valid_out = valid_q;
  assign fetch_instr_out = instr_q;
  assign fetch_pc_out    = fpc_q;
  assign fetch_pred_out  = pred_q;

  // Next-state, next-PC and output-register update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    fpc_d    = fpc_q;
    pred_d   = pred_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (fetch_correction_en_in) pc_d = fetch_correction_addr_in;
      end

      ST_REQ: begin
        if (fetch_correction_en_in) begin
          pc_d    = fetch_correction_addr_in;
          valid_d = 1'b0;
          pred_d  = 1'b0;
          if (!imem_ack_in) begin
            // Request still outstanding: drain it before re-targeting.
            instr_d  = '0;
            fpc_d    = '0;
            shadow_d = pc_q;
            state_d  = ST_FLUSH;
          end
        end else if (imem_ack_in) begin
          instr_d = imem_data_in;
          fpc_d   = pc_q;
          pred_d  = w_pred_en;
          valid_d = 1'b1;
          pc_d    = w_pred_en ? w_pred_addr : (pc_q + C_PC_STEP);
          state_d = fetch_stall_in ? ST_HOLD : ST_REQ;
        end else if (!fetch_stall_in) begin
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (fetch_correction_en_in) begin
          pc_d    = fetch_correction_addr_in;
          valid_d = 1'b0;
          pred_d  = 1'b0;
          instr_d = '0;
          fpc_d   = '0;
          state_d = ST_REQ;
        end else if (!fetch_stall_in) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end

      ST_FLUSH: begin
        // Returning data belongs to the abandoned path and is dropped.
        if (fetch_correction_en_in) pc_d = fetch_correction_addr_in;
        if (imem_ack_in) state_d = ST_REQ;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // State and datapath registers; reset abandons any request immediately.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      fpc_q    <= '0;
      pred_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      fpc_q    <= fpc_d;
      pred_q   <= pred_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed self-checking bench for pc_fetch_ctrl. A second
//            instance with a high reset vector exercises PC wrap-around.
//            Honours PC_FETCH_CTRL_PREDICTION_EN for the prediction step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;
`ifdef PC_FETCH_CTRL_PREDICTION_EN
  localparam logic        EXP_PRED = 1'b1;
  localparam logic [31:0] EXP_TGT  = 32'h0000_0040;
`else
  localparam logic        EXP_PRED = 1'b0;
  localparam logic [31:0] EXP_TGT  = 32'h0000_0024;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, corr_en, pred_en, ack;
  logic [31:0] corr_addr, pred_addr, imem_data;
  logic        req, valid, pred;
  logic [31:0] addr, instr, fpc;
  logic        w_req, w_valid, w_pred;
  logic [31:0] w_addr, w_instr, w_fpc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_data = addr ^ XOR_PAT;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clock_in(clk), .reset_in(rst_n), .fetch_stall_in(stall),
    .fetch_correction_en_in(corr_en), .fetch_correction_addr_in(corr_addr),
    .fetch_prediction_en_in(pred_en), .fetch_prediction_addr_in(pred_addr),
    .imem_req_out(req), .imem_addr_out(addr), .imem_ack_in(ack),
    .imem_data_in(imem_data), .fetch_valid_out(valid),
    .fetch_instr_out(instr), .fetch_pc_out(fpc), .fetch_pred_out(pred)
  );

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
    .clock_in(clk), .reset_in(rst_n), .fetch_stall_in(stall),
    .fetch_correction_en_in(corr_en), .fetch_correction_addr_in(corr_addr),
    .fetch_prediction_en_in(pred_en), .fetch_prediction_addr_in(pred_addr),
    .imem_req_out(w_req), .imem_addr_out(w_addr), .imem_ack_in(ack),
    .imem_data_in(imem_data), .fetch_valid_out(w_valid),
    .fetch_instr_out(w_instr), .fetch_pc_out(w_fpc), .fetch_pred_out(w_pred)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; corr_en = 1'b0; pred_en = 1'b0; ack = 1'b0;
    corr_addr = '0; pred_addr = '0;
    tick(); tick();
    chk("rst_req",   {31'd0, req},   32'd0);
    chk("rst_addr",  addr,           32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pred",  {31'd0, pred},  32'd0);
    chk("rst_instr", instr,          32'h0);
    chk("rst_fpc",   fpc,            32'h0);
    chk("rst_waddr", w_addr,         32'hFFFF_FFF8);

    // Release reset with memory acking every cycle.
    rst_n = 1'b1; ack = 1'b1;
    chk("boot_req", {31'd0, req}, 32'd0);
    tick();
    chk("r0_req",   {31'd0, req},   32'd1);
    chk("r0_addr",  addr,           32'h0);
    chk("r0_valid", {31'd0, valid}, 32'd0);
    chk("w0_addr",  w_addr,         32'hFFFF_FFF8);
    tick();
    chk("r1_addr",  addr,           32'h4);
    chk("r1_valid", {31'd0, valid}, 32'd1);
    chk("r1_fpc",   fpc,            32'h0);
    chk("r1_instr", instr,          32'hA5A5_0000);
    chk("w1_addr",  w_addr,         32'hFFFF_FFFC);
    chk("w1_fpc",   w_fpc,          32'hFFFF_FFF8);
    tick();
    chk("r2_addr",  addr,   32'h8);
    chk("r2_fpc",   fpc,    32'h4);
    chk("w2_addr",  w_addr, 32'h0);

    // Stall on the acceptance of 8: hold for three cycles.
    stall = 1'b1;
    tick();
    chk("h0_req",   {31'd0, req},   32'd0);
    chk("h0_valid", {31'd0, valid}, 32'd1);
    chk("h0_fpc",   fpc,            32'h8);
    chk("h0_instr", instr,          32'hA5A5_0008);
    tick();
    chk("h1_req", {31'd0, req}, 32'd0);
    chk("h1_fpc", fpc,          32'h8);
    tick();
    chk("h2_req", {31'd0, req}, 32'd0);
    chk("h2_fpc", fpc,          32'h8);
    stall = 1'b0;
    tick();
    chk("res_req",   {31'd0, req},   32'd1);
    chk("res_addr",  addr,           32'hC);
    chk("res_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("c_valid", {31'd0, valid}, 32'd1);
    chk("c_fpc",   fpc,            32'hC);
    chk("c_addr",  addr,           32'h10);

    // Correction while 0x10 is outstanding.
    ack = 1'b0;
    tick();
    chk("wait_addr",  addr,           32'h10);
    chk("wait_valid", {31'd0, valid}, 32'd0);
    corr_en = 1'b1; corr_addr = 32'h100;
    tick();
    chk("fl0_req",   {31'd0, req},   32'd1);
    chk("fl0_addr",  addr,           32'h10);
    chk("fl0_valid", {31'd0, valid}, 32'd0);
    corr_en = 1'b0;
    tick();
    chk("fl1_addr",  addr,           32'h10);
    chk("fl1_valid", {31'd0, valid}, 32'd0);
    ack = 1'b1;
    tick();
    chk("fl2_addr",  addr,           32'h100);
    chk("fl2_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("n100_valid", {31'd0, valid}, 32'd1);
    chk("n100_fpc",   fpc,            32'h100);
    chk("n100_addr",  addr,           32'h104);

    // Correction coinciding with an ack discards the data.
    corr_en = 1'b1; corr_addr = 32'h20;
    tick();
    chk("ca_addr",  addr,           32'h20);
    chk("ca_valid", {31'd0, valid}, 32'd0);
    chk("ca_pred",  {31'd0, pred},  32'd0);

    // Predicted-taken on the ack of 0x20.
    corr_en = 1'b0; pred_en = 1'b1; pred_addr = 32'h40;
    tick();
    chk("p_valid", {31'd0, valid}, 32'd1);
    chk("p_fpc",   fpc,            32'h20);
    chk("p_pred",  {31'd0, pred},  {31'd0, EXP_PRED});
    chk("p_addr",  addr,           EXP_TGT);
    pred_en = 1'b0;
    tick();
    chk("pt_fpc",  fpc,           EXP_TGT);
    chk("pt_pred", {31'd0, pred}, 32'd0);
    chk("pt_addr", addr,          EXP_TGT + 32'd4);

    // Correction out of HOLD while stall stays high.
    stall = 1'b1;
    tick();
    chk("hc0_req",   {31'd0, req},   32'd0);
    chk("hc0_valid", {31'd0, valid}, 32'd1);
    chk("hc0_fpc",   fpc,            EXP_TGT + 32'd4);
    corr_en = 1'b1; corr_addr = 32'h200;
    tick();
    chk("hc1_req",   {31'd0, req},   32'd1);
    chk("hc1_addr",  addr,           32'h200);
    chk("hc1_valid", {31'd0, valid}, 32'd0);
    corr_en = 1'b0; stall = 1'b0;
    tick();
    chk("a200_valid", {31'd0, valid}, 32'd1);
    chk("a200_fpc",   fpc,            32'h200);
    chk("a200_addr",  addr,           32'h204);

    // Unacked request with stall keeps valid, then reset mid-request.
    ack = 1'b0; stall = 1'b1;
    tick();
    chk("ns_valid", {31'd0, valid}, 32'd1);
    chk("ns_req",   {31'd0, req},   32'd1);
    chk("ns_addr",  addr,           32'h204);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'd0, req},   32'd0);
    chk("ar_addr",  addr,           32'h0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_fpc",   fpc,            32'h0);
    chk("ar_instr", instr,          32'h0);
    chk("ar_pred",  {31'd0, pred},  32'd0);
    tick();
    rst_n = 1'b1; stall = 1'b0; ack = 1'b1;
    chk("rb_req", {31'd0, req}, 32'd0);
    tick();
    chk("rr_req",   {31'd0, req},   32'd1);
    chk("rr_addr",  addr,           32'h0);
    chk("rr_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("rf_valid", {31'd0, valid}, 32'd1);
    chk("rf_fpc",   fpc,            32'h0);
    chk("rf_addr",  addr,           32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
